semi_auto_nav: RTL

Parametrised successor to the semi-automatic driving controller. It accepts one-shot manual direction commands and debounces the obstacle detector. It issues timed turn-trigger pulses to the turn engine and then follows corridors autonomously, turning at single-exit junctions. It sits between the manual-input decoder and the motion/turn engine. Unlike its predecessor, it adds:
- configurable trigger width;
- detector debouncing;
- a turn-timeout fault state;
- an enable that aborts cleanly.

---
 rtl/semi_nav_pkg.sv | 34 +++
 rtl/det_debounce.sv | 43 ++++
 rtl/semi_auto_nav.sv | 135 +++++++++++++
 3 files changed

// File: rtl/semi_nav_pkg.sv
// Shared types and constants for the semi-automatic navigation controller.
package semi_nav_pkg;

    typedef enum logic [2:0] {
        WAITING,
        TRIGGER,
        TURNING,
        SETTLE,
        MOVING,
        FAULT
    } state_t;

    typedef enum logic [1:0] {
        L,
        R,
        B
    } dir_t;

    localparam int DET_FRONT = 3;
    localparam int DET_BACK  = 2;
    localparam int DET_LEFT  = 1;
    localparam int DET_RIGHT = 0;

    localparam logic [3:0] JUNC_L   = 4'b1001;
    localparam logic [3:0] JUNC_R   = 4'b1010;
    localparam logic [3:0] DEAD_END = 4'b1011;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/det_debounce.sv
// Obstacle-detector debouncer: the filtered value follows the raw input only
// after STABLE_CYCLES consecutive identical samples that differ from it.
module det_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] raw,
    output logic [3:0] det_s
);

    logic [3:0]       last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run;

    // Length of the current run of identical samples, including this one.
    always_comb begin
        run = CNT_W'(1);
        if (raw == last && cnt != '0) begin
            run = (cnt == '1) ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            det_s <= 4'b1111;
            last  <= 4'b1111;
            cnt   <= '0;
        end else begin
            last <= raw;
            if (raw == det_s) begin
                cnt <= '0;
            end else if (run >= CNT_W'(STABLE_CYCLES)) begin
                det_s <= raw;
                cnt   <= '0;
            end else begin
                cnt <= run;
            end
        end
    end

endmodule

// File: rtl/semi_auto_nav.sv
// Semi-automatic navigation controller: manual one-shot commands, timed turn
// triggers, corridor following. Build macro SEMI_AUTO_BACK_EN: automatic U-turn at dead ends.
module semi_auto_nav #(
    parameter int         TRIG_CYCLES   = 5,
    parameter int         STABLE_CYCLES = 4,
    parameter int         TURN_TIMEOUT  = 1000,
    parameter logic [3:0] CORRIDOR      = 4'b0011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       is_turning,
    input  logic       move_forward,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       move_backward,
    input  logic [3:0] detector,
    output logic       out_move_forward,
    output logic       trigger_turn_left,
    output logic       trigger_turn_right,
    output logic       trigger_turn_back,
    output logic       fault
);
    import semi_nav_pkg::*;

    localparam int CNT_W = $clog2(max3(TRIG_CYCLES, TURN_TIMEOUT, STABLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TURN_TIMEOUT);

    state_t           state, next_state;
    dir_t             dir, next_dir;
    logic [CNT_W-1:0] cnt, next_cnt, cnt_inc;
    logic [3:0]       det_s;
    logic             one_cmd;

    det_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (detector),
        .det_s(det_s)
    );

    always_comb begin
        next_state = state;
        next_dir   = dir;
        next_cnt   = '0;
        cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
        one_cmd    = $onehot({move_forward, move_left, move_right, move_backward});

        case (state)
            WAITING: begin
                if (one_cmd) begin
                    if (move_forward && !det_s[DET_FRONT]) begin
                        next_state = SETTLE;
                    end else if (move_left && !det_s[DET_LEFT]) begin
                        next_state = TRIGGER;
                        next_dir   = L;
                    end else if (move_right && !det_s[DET_RIGHT]) begin
                        next_state = TRIGGER;
                        next_dir   = R;
                    end else if (move_backward) begin
                        next_state = TRIGGER;
                        next_dir   = B;
                    end
                end
            end
            TRIGGER: begin
                if (cnt >= TRIG_LAST) next_state = TURNING;
                else                  next_cnt   = cnt_inc;
            end
            TURNING: begin
                // Timeout wins a tie with the turn engine going idle.
                if (cnt >= TIMEOUT_C)               next_state = FAULT;
                else if (!is_turning && cnt != '0)  next_state = SETTLE;
                else                                next_cnt   = cnt_inc;
            end
            SETTLE: begin
                if (det_s == CORRIDOR) next_state = MOVING;
            end
            MOVING: begin
                if (det_s != CORRIDOR) begin
                    if (det_s == JUNC_L) begin
                        next_state = TRIGGER;
                        next_dir   = L;
                    end else if (det_s == JUNC_R) begin
                        next_state = TRIGGER;
                        next_dir   = R;
                    end
`ifdef SEMI_AUTO_BACK_EN
                    else if (det_s == DEAD_END) begin
                        next_state = TRIGGER;
                        next_dir   = B;
                    end
`endif
                    else begin
                        next_state = WAITING;
                    end
                end
            end
            FAULT:   next_state = FAULT;
            default: next_state = WAITING;
        endcase

        if (!enable) begin
            next_state = WAITING;
            next_cnt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= WAITING;
            dir                <= L;
            cnt                <= '0;
            out_move_forward   <= 1'b0;
            trigger_turn_left  <= 1'b0;
            trigger_turn_right <= 1'b0;
            trigger_turn_back  <= 1'b0;
            fault              <= 1'b0;
        end else begin
            state              <= next_state;
            dir                <= next_dir;
            cnt                <= next_cnt;
            out_move_forward   <= (next_state == SETTLE) || (next_state == MOVING);
            trigger_turn_left  <= (next_state == TRIGGER) && (next_dir == L);
            trigger_turn_right <= (next_state == TRIGGER) && (next_dir == R);
            trigger_turn_back  <= (next_state == TRIGGER) && (next_dir == B);
            fault              <= (next_state == FAULT);
        end
    end

endmodule
